// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// HALF x HALF unsigned shift-add multiplier, one partial product per step.
// product/ready describe the result of the step being taken this cycle.
module mul_shift_add #(
  parameter int HALF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] product,
  output logic              ready
);

  localparam int CW = $clog2(HALF + 1);

  logic [2*HALF-1:0] acc;
  logic [2*HALF-1:0] mcand;
  logic [HALF-1:0]   mplier;
  logic [CW-1:0]     count;

  // Down-counter terminal value 1: the current step is the last one.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign ready   = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{HALF{1'b0}}, a};
      mplier <= b;
      count  <= CW'(HALF);
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and iterative multiply.
// Optional zero/carry flags are built when ALU_FLAGS_EN is defined.
//
// state   | meaning
// IDLE    | accepting start; single-cycle ops complete here
// MUL     | multiplier stepping, busy=1, start ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry
`endif
);

  localparam int HALF = WIDTH / 2;

  state_t           state_q, state_d;
  logic             mul_load, mul_step, mul_ready;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             accept_op;

  mul_shift_add #(.HALF(HALF)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a[HALF-1:0]),
    .b       (b[HALF-1:0]),
    .product (mul_product),
    .ready   (mul_ready)
  );

  always_comb begin
    alu_res = '0;
    case (f)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    accept_op = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (f == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            accept_op = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_MUL);

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_full;
  logic           alu_cy;

  assign add_full = {1'b0, a} + {1'b0, b};

  always_comb begin
    alu_cy = 1'b0;
    if (f == OP_ADD)      alu_cy = add_full[WIDTH];
    else if (f == OP_SUB) alu_cy = (a >= b);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r       <= '0;
      done    <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero    <= 1'b0;
      carry   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept_op) begin
        r    <= alu_res;
        done <= 1'b1;
`ifdef ALU_FLAGS_EN
        zero  <= (alu_res == '0);
        carry <= alu_cy;
`endif
      end else if (mul_step && mul_ready) begin
        r    <= mul_product;
        done <= 1'b1;
`ifdef ALU_FLAGS_EN
        zero  <= (mul_product == '0);
        carry <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: cycle model of the handshake plus
// directed literal checks and randomized traffic.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [2:0]  f;
  logic [31:0] r;
  logic        done, busy;
`ifdef ALU_FLAGS_EN
  logic        zero, carry;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .f     (f),
    .r     (r),
    .done  (done),
    .busy  (busy)
`ifdef ALU_FLAGS_EN
    ,
    .zero  (zero),
    .carry (carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: result and carry straight from the opcode definitions.
  function automatic logic [32:0] ref_op(input logic [2:0] tf, input logic [31:0] ta,
                                         input logic [31:0] tb);
    longint s;
    logic [32:0] o;
    o = '0;
    case (tf)
      3'd0: begin s = longint'(ta) + longint'(tb); o = {s >= 64'h1_0000_0000, ta + tb}; end
      3'd1: o = {ta >= tb, ta - tb};
      3'd3: o = {1'b0, ta & tb};
      3'd4: o = {1'b0, ta | tb};
      3'd5: o = {1'b0, ta ^ tb};
      3'd6: o = {1'b0, (ta < tb) ? 32'd1 : 32'd0};
      default: o = '0;
    endcase
    return o;
  endfunction

  logic [31:0] exp_r = '0;
  logic        exp_done = 1'b0;
  logic        exp_zero = 1'b0, exp_carry = 1'b0;
  int          mul_left = 0;
  logic [31:0] mul_prod;

  always @(posedge clk) begin
    logic [32:0] o;
    if (rst) begin
      exp_r = '0; exp_done = 1'b0; exp_zero = 1'b0; exp_carry = 1'b0; mul_left = 0;
    end else begin
      exp_done = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          exp_r = mul_prod; exp_done = 1'b1;
          exp_zero = (mul_prod == 0); exp_carry = 1'b0;
        end
      end else if (start) begin
        if (f == 3'd2) begin
          mul_prod = 32'(a[15:0]) * 32'(b[15:0]);
          mul_left = 16;
        end else begin
          o = ref_op(f, a, b);
          exp_r = o[31:0]; exp_done = 1'b1;
          exp_zero = (o[31:0] == 0); exp_carry = o[32];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("r", r, exp_r);
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(mul_left > 0));
`ifdef ALU_FLAGS_EN
    chk("zero", 32'(zero), 32'(exp_zero));
    chk("carry", 32'(carry), 32'(exp_carry));
`endif
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf);
    start = 1'b1; a = ta; b = tb; f = tf;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 1;
    while (!done && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("timeout", 32'(cyc), 32'(lim + 1));
  endtask

  task automatic op_lit(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [2:0] tf, input logic [31:0] want);
    issue(ta, tb, tf);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk(nm, r, want);
  endtask

  initial begin
    int cyc, nb, seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; f = '0;
    repeat (2) @(negedge clk);
    chk("rst_r", r, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd2, 32'd3, 3'd0);
    chk("add_done", 32'(done), 32'd1);
    chk("add", r, 32'd5);
    chk("add_busy", 32'(busy), 32'd0);
`ifdef ALU_FLAGS_EN
    chk("add_carry", 32'(carry), 32'd0);
    chk("add_zero", 32'(zero), 32'd0);
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    op_lit("sub_neg", 32'd2, 32'd3, 3'd1, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
    chk("sub_borrow", 32'(carry), 32'd0);
`endif
    op_lit("sub_zero", 32'd3, 32'd3, 3'd1, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("sub_z", 32'(zero), 32'd1);
    chk("sub_c", 32'(carry), 32'd1);
`endif
    op_lit("add_wrap", 32'hFFFF_FFFF, 32'd2, 3'd0, 32'd1);
    op_lit("sltu1", 32'd2, 32'd3, 3'd6, 32'd1);
    op_lit("sltu0", 32'd3, 32'd2, 3'd6, 32'd0);
    op_lit("rsv", 32'd3, 32'd2, 3'd7, 32'd0);
    op_lit("and", 32'hF0F0, 32'hFF00, 3'd3, 32'hF000);
    op_lit("or", 32'hF0F0, 32'hFF00, 3'd4, 32'hFFF0);
    op_lit("xor", 32'hF0F0, 32'hFF00, 3'd5, 32'h0FF0);

    // MUL with an ignored start and an operand change while busy
    issue(32'h1234_FFFF, 32'hABCD_FFFF, 3'd2);
    cyc = 1; nb = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      start = (cyc == 4);
      f = (cyc == 4) ? 3'd0 : 3'd2;
      if (cyc == 6) b = 32'd0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("mul_latency", 32'(cyc), 32'd17);
    chk("mul_busy_cycles", 32'(nb), 32'd16);
    chk("mul_result", r, 32'hFFFE_0001);
    chk("mul_busy_at_done", 32'(busy), 32'd0);
    op_lit("b2b_add", 32'd5, 32'd6, 3'd0, 32'd11);

    // reset mid-MUL discards the product
    issue(32'd7, 32'd6, 3'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mul_busy", 32'(busy), 32'd0);
    chk("rst_mul_r", r, 32'd0);
    seen = 0;
    repeat (20) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("rst_mul_no_done", 32'(seen), 32'd0);
    issue(32'd7, 32'd6, 3'd2);
    wait_done(40, cyc);
    chk("mul42_latency", 32'(cyc), 32'd17);
    chk("mul42", r, 32'd42);

    // reset and start together: start is lost
    rst = 1'b1;
    issue(32'd1, 32'd1, 3'd0);
    rst = 1'b0;
    chk("rst_start_done", 32'(done), 32'd0);
    chk("rst_start_r", r, 32'd0);
    @(negedge clk);
    chk("rst_start_lost", 32'(done), 32'd0);

    // randomized traffic; the cycle model checks every output each cycle
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) != 0);
      f     = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, 7));
        b = 32'($urandom_range(0, 7));
      end else begin
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
